knn_ctrl: RTL and testbench

Sequencer for `knn_core`. It fetches each test point from test memory and clears the core. It then streams every training point with its label into the core, waits for the neighbour list to settle, and reduces the K nearest labels to one classification by majority vote. Results go out on a valid/ready port, one per test point. It sits between the memory-mapped KNN peripheral registers/memories and `knn_core`.

---
 rtl/knn_pkg.sv | 33 +++
 rtl/knn_vote.sv | 60 ++++++
 rtl/knn_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_knn_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// knn_pkg: shared definitions for the KNN sequencer slice.
//   - default widths for points, labels, addresses and neighbour count
//   - neighbour entry width and field offsets ({distance, label}, label low)
//   - the all-ones "unfilled entry" distance constant
//   - controller state encoding
package knn_pkg;

  localparam int KNN_DATA_W      = 32;
  localparam int KNN_LABEL_W     = 8;
  localparam int KNN_N_NEIGHBOUR = 4;
  localparam int KNN_TRAIN_AW    = 10;
  localparam int KNN_TEST_AW     = 8;
  localparam int KNN_CORE_LAT    = 1;

  // One neighbour entry: distance in the high bits, label in the low bits.
  localparam int KNN_ENTRY_W   = KNN_DATA_W + KNN_LABEL_W;
  localparam int KNN_LABEL_LSB = 0;
  localparam int KNN_DIST_LSB  = KNN_LABEL_W;

  // Distance value the core reports for an entry that holds no candidate.
  localparam logic [KNN_DATA_W-1:0] KNN_DIST_NONE = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_A,
    ST_LOAD_A,
    ST_STREAM,
    ST_DRAIN,
    ST_VOTE,
    ST_OUT
  } knn_state_e;

endpackage

// File: rtl/knn_vote.sv
// knn_vote: combinational majority vote over the K neighbour entries.
//   nbr   in  (DATA_W+LABEL_W)*N_NEIGHBOUR  packed entries, entry 0 nearest
//   label out LABEL_W                       winning label (0 if no entry filled)
// Each filled entry counts how many filled entries share its label; the entry
// with the highest count wins, and scanning from entry 0 with a strict
// comparison makes the lowest-index (nearest) entry win ties.
module knn_vote
  import knn_pkg::*;
#(
  parameter int DATA_W      = KNN_DATA_W,
  parameter int LABEL_W     = KNN_LABEL_W,
  parameter int N_NEIGHBOUR = KNN_N_NEIGHBOUR
) (
  input  logic [(DATA_W+LABEL_W)*N_NEIGHBOUR-1:0] nbr,
  output logic [LABEL_W-1:0]                      label
);

  localparam int EW = DATA_W + LABEL_W;
  localparam int CW = $clog2(N_NEIGHBOUR + 1);

  logic [LABEL_W-1:0]     lbl [N_NEIGHBOUR];
  logic [N_NEIGHBOUR-1:0] vld;
  logic [CW-1:0]          cnt [N_NEIGHBOUR];

  genvar gi;
  generate
    for (gi = 0; gi < N_NEIGHBOUR; gi++) begin : g_entry
      logic [CW-1:0] match_cnt;

      assign lbl[gi] = nbr[gi*EW +: LABEL_W];
      // An all-ones distance marks an unfilled entry.
      assign vld[gi] = ~&nbr[gi*EW+LABEL_W +: DATA_W];

      always_comb begin
        match_cnt = '0;
        for (int j = 0; j < N_NEIGHBOUR; j++) begin
          if (vld[gi] && vld[j] && (lbl[j] == lbl[gi])) begin
            match_cnt = match_cnt + CW'(1);
          end
        end
      end

      assign cnt[gi] = match_cnt;
    end
  endgenerate

  // Unfilled entries carry a count of 0 and can never beat the initial best.
  always_comb begin
    logic [CW-1:0] best_cnt;
    best_cnt = '0;
    label    = '0;
    for (int i = 0; i < N_NEIGHBOUR; i++) begin
      if (cnt[i] > best_cnt) begin
        best_cnt = cnt[i];
        label    = lbl[i];
      end
    end
  end

endmodule

// File: rtl/knn_ctrl.sv
// knn_ctrl: sequencer for knn_core.
// For each test point: fetch it, clear the core, stream every training point
// into the core, wait for the neighbour list to settle, vote, and present the
// result on a valid/ready port.
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   run, stop                         job start pulse / synchronous abort
//   cfg_n_train, cfg_n_test           point counts, latched on run
//   busy, done                        not-idle flag / end-of-job pulse
//   train_addr, train_rdata           training memory (1-cycle read)
//   test_addr, test_rdata             test memory (1-cycle read)
//   knn_a, knn_b, knn_label,
//   knn_valid, knn_start, knn_nbr     core interface
//   res_valid, res_ready, res_idx,
//   res_label, res_nbr                result port
module knn_ctrl
  import knn_pkg::*;
#(
  parameter int DATA_W      = KNN_DATA_W,
  parameter int LABEL_W     = KNN_LABEL_W,
  parameter int N_NEIGHBOUR = KNN_N_NEIGHBOUR,
  parameter int TRAIN_AW    = KNN_TRAIN_AW,
  parameter int TEST_AW     = KNN_TEST_AW,
  parameter int CORE_LAT    = KNN_CORE_LAT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    run,
  input  logic                                    stop,
  input  logic [TRAIN_AW:0]                       cfg_n_train,
  input  logic [TEST_AW:0]                        cfg_n_test,
  output logic                                    busy,
  output logic                                    done,
  output logic [TRAIN_AW-1:0]                     train_addr,
  input  logic [DATA_W+LABEL_W-1:0]               train_rdata,
  output logic [TEST_AW-1:0]                      test_addr,
  input  logic [DATA_W-1:0]                       test_rdata,
  output logic [DATA_W-1:0]                       knn_a,
  output logic [DATA_W-1:0]                       knn_b,
  output logic [LABEL_W-1:0]                      knn_label,
  output logic                                    knn_valid,
  output logic                                    knn_start,
  input  logic [(DATA_W+LABEL_W)*N_NEIGHBOUR-1:0] knn_nbr,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [TEST_AW-1:0]                      res_idx,
  output logic [LABEL_W-1:0]                      res_label,
  output logic [(DATA_W+LABEL_W)*N_NEIGHBOUR-1:0] res_nbr
);

  localparam int NBR_W  = (DATA_W + LABEL_W) * N_NEIGHBOUR;
  localparam int DCNT_W = $clog2(CORE_LAT + 1) + 1;

  knn_state_e state_reg, state_next;

  logic [TRAIN_AW:0]     n_train_reg;
  logic [TEST_AW:0]      n_test_reg;
  logic [TRAIN_AW:0]     train_idx_reg;
  logic [TEST_AW:0]      test_idx_reg;
  logic [DCNT_W-1:0]     drain_cnt_reg;
  logic                  valid_reg;
  logic                  done_reg;
  logic [DATA_W-1:0]     knn_a_reg;
  logic [TEST_AW-1:0]    res_idx_reg;
  logic [LABEL_W-1:0]    res_label_reg;
  logic [NBR_W-1:0]      res_nbr_reg;
  logic [LABEL_W-1:0]    vote_label;

  logic cfg_zero;
  logic train_last;
  logic test_last;
  logic handshake;

  assign cfg_zero   = (cfg_n_train == '0) || (cfg_n_test == '0);
  assign train_last = (train_idx_reg == n_train_reg - 1'b1);
  assign test_last  = (test_idx_reg == n_test_reg - 1'b1);
  assign handshake  = (state_reg == ST_OUT) && res_ready;

  knn_vote #(
    .DATA_W      (DATA_W),
    .LABEL_W     (LABEL_W),
    .N_NEIGHBOUR (N_NEIGHBOUR)
  ) u_vote (
    .nbr   (knn_nbr),
    .label (vote_label)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (run && !cfg_zero) state_next = ST_FETCH_A;
      ST_FETCH_A: state_next = ST_LOAD_A;
      ST_LOAD_A:  state_next = ST_STREAM;
      ST_STREAM:  if (train_last) state_next = ST_DRAIN;
      ST_DRAIN:   if (drain_cnt_reg == DCNT_W'(CORE_LAT)) state_next = ST_VOTE;
      ST_VOTE:    state_next = ST_OUT;
      ST_OUT:     if (res_ready) state_next = test_last ? ST_IDLE : ST_FETCH_A;
      default:    state_next = ST_IDLE;
    endcase
    if (stop) begin
      state_next = ST_IDLE;
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_train_reg   <= '0;
      n_test_reg    <= '0;
      train_idx_reg <= '0;
      test_idx_reg  <= '0;
      drain_cnt_reg <= '0;
      valid_reg     <= 1'b0;
      done_reg      <= 1'b0;
      knn_a_reg     <= '0;
      res_idx_reg   <= '0;
      res_label_reg <= '0;
      res_nbr_reg   <= '0;
    end else if (stop) begin
      // Abort clears everything so the outputs read as after reset.
      n_train_reg   <= '0;
      n_test_reg    <= '0;
      train_idx_reg <= '0;
      test_idx_reg  <= '0;
      drain_cnt_reg <= '0;
      valid_reg     <= 1'b0;
      done_reg      <= 1'b0;
      knn_a_reg     <= '0;
      res_idx_reg   <= '0;
      res_label_reg <= '0;
      res_nbr_reg   <= '0;
    end else begin
      done_reg  <= 1'b0;
      // A candidate is presented the cycle after its address is issued.
      valid_reg <= (state_reg == ST_STREAM);
      case (state_reg)
        ST_IDLE: begin
          if (run) begin
            n_train_reg  <= cfg_n_train;
            n_test_reg   <= cfg_n_test;
            test_idx_reg <= '0;
            done_reg     <= cfg_zero;
          end
        end
        ST_FETCH_A: begin
          train_idx_reg <= '0;
        end
        ST_LOAD_A: begin
          knn_a_reg     <= test_rdata;
          drain_cnt_reg <= '0;
        end
        ST_STREAM: begin
          train_idx_reg <= train_idx_reg + 1'b1;
        end
        ST_DRAIN: begin
          drain_cnt_reg <= drain_cnt_reg + 1'b1;
        end
        ST_VOTE: begin
          res_label_reg <= vote_label;
          res_nbr_reg   <= knn_nbr;
          res_idx_reg   <= test_idx_reg[TEST_AW-1:0];
        end
        ST_OUT: begin
          if (handshake) begin
            test_idx_reg <= test_idx_reg + 1'b1;
            done_reg     <= test_last;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------ outputs
  assign busy       = (state_reg != ST_IDLE);
  assign done       = done_reg;
  assign train_addr = train_idx_reg[TRAIN_AW-1:0];
  assign test_addr  = test_idx_reg[TEST_AW-1:0];
  assign knn_a      = knn_a_reg;
  // Candidate operands come straight from the memory read port; gated so
  // they read 0 outside candidate cycles.
  assign knn_b      = valid_reg ? train_rdata[DATA_W-1:0] : '0;
  assign knn_label  = valid_reg ? train_rdata[DATA_W +: LABEL_W] : '0;
  assign knn_valid  = valid_reg;
  // Core is held clear in FETCH_A/LOAD_A and enabled from STREAM until the
  // result is taken, so knn_nbr holds through DRAIN, VOTE and OUT.
  assign knn_start  = (state_reg == ST_STREAM) || (state_reg == ST_DRAIN) ||
                      (state_reg == ST_VOTE)   || (state_reg == ST_OUT);
  assign res_valid  = (state_reg == ST_OUT);
  assign res_idx    = res_idx_reg;
  assign res_label  = res_label_reg;
  assign res_nbr    = res_nbr_reg;

endmodule

// File: tb/tb_knn_ctrl.sv
// tb_knn_ctrl: directed testbench for knn_ctrl with behavioural memories and
// a small behavioural KNN core (squared Euclidean distance, sorted insert).
module tb_knn_ctrl;

  localparam int DATA_W   = 32;
  localparam int LABEL_W  = 8;
  localparam int K        = 4;
  localparam int TRAIN_AW = 10;
  localparam int TEST_AW  = 8;
  localparam int EW       = DATA_W + LABEL_W;
  localparam int NBR_W    = EW * K;

  logic                  clk;
  logic                  rst;
  logic                  run;
  logic                  stop;
  logic [TRAIN_AW:0]     cfg_n_train;
  logic [TEST_AW:0]      cfg_n_test;
  logic                  busy;
  logic                  done;
  logic [TRAIN_AW-1:0]   train_addr;
  logic [EW-1:0]         train_rdata;
  logic [TEST_AW-1:0]    test_addr;
  logic [DATA_W-1:0]     test_rdata;
  logic [DATA_W-1:0]     knn_a;
  logic [DATA_W-1:0]     knn_b;
  logic [LABEL_W-1:0]    knn_label;
  logic                  knn_valid;
  logic                  knn_start;
  logic [NBR_W-1:0]      knn_nbr;
  logic                  res_valid;
  logic                  res_ready;
  logic [TEST_AW-1:0]    res_idx;
  logic [LABEL_W-1:0]    res_label;
  logic [NBR_W-1:0]      res_nbr;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int kv_seen = 0;
  int rv_seen = 0;

  knn_ctrl #(
    .DATA_W(DATA_W), .LABEL_W(LABEL_W), .N_NEIGHBOUR(K),
    .TRAIN_AW(TRAIN_AW), .TEST_AW(TEST_AW), .CORE_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .stop(stop),
    .cfg_n_train(cfg_n_train), .cfg_n_test(cfg_n_test),
    .busy(busy), .done(done),
    .train_addr(train_addr), .train_rdata(train_rdata),
    .test_addr(test_addr), .test_rdata(test_rdata),
    .knn_a(knn_a), .knn_b(knn_b), .knn_label(knn_label),
    .knn_valid(knn_valid), .knn_start(knn_start), .knn_nbr(knn_nbr),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
    .res_label(res_label), .res_nbr(res_nbr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------- memories
  logic [EW-1:0]     train_mem [0:(1<<TRAIN_AW)-1];
  logic [DATA_W-1:0] test_mem  [0:(1<<TEST_AW)-1];

  always @(posedge clk) begin
    train_rdata <= train_mem[train_addr];
    test_rdata  <= test_mem[test_addr];
  end

  // ------------------------------------------------- behavioural core
  logic [DATA_W-1:0]  core_d [K];
  logic [LABEL_W-1:0] core_l [K];

  function automatic logic [DATA_W-1:0] sqdist(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [15:0] dx, dy;
    dx = (a[15:0] > b[15:0]) ? a[15:0] - b[15:0] : b[15:0] - a[15:0];
    dy = (a[31:16] > b[31:16]) ? a[31:16] - b[31:16] : b[31:16] - a[31:16];
    return DATA_W'(dx) * DATA_W'(dx) + DATA_W'(dy) * DATA_W'(dy);
  endfunction

  always @(posedge clk or negedge rst) begin : core_model
    int ins;
    logic [DATA_W-1:0] d;
    if (!rst || !knn_start) begin
      for (int i = 0; i < K; i++) begin
        core_d[i] <= '1;
        core_l[i] <= '0;
      end
    end else if (knn_valid) begin
      d = sqdist(knn_a, knn_b);
      ins = K;
      for (int i = 0; i < K; i++) begin
        if (ins == K && d < core_d[i]) ins = i;
      end
      for (int i = 0; i < K; i++) begin
        if (i == ins) begin
          core_d[i] <= d;
          core_l[i] <= knn_label;
        end else if (i > ins) begin
          core_d[i] <= core_d[i-1];
          core_l[i] <= core_l[i-1];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_nbr
      assign knn_nbr[gi*EW +: EW] = {core_d[gi], core_l[gi]};
    end
  endgenerate

  // --------------------------------------------------------- helpers
  function automatic logic [DATA_W-1:0] pt(input int x, input int y);
    return {y[15:0], x[15:0]};
  endfunction

  function automatic logic [EW-1:0] ent(input logic [DATA_W-1:0] d, input logic [LABEL_W-1:0] l);
    return {d, l};
  endfunction

  localparam logic [DATA_W-1:0] NONE = '1;

  task automatic tick();
    @(posedge clk);
    #1;
    if (done)      done_seen++;
    if (knn_valid) kv_seen++;
    if (res_valid) rv_seen++;
  endtask

  task automatic set_train(input int i, input int x, input int y, input int l);
    train_mem[i] = {l[LABEL_W-1:0], pt(x, y)};
  endtask

  task automatic load_basic();
    test_mem[0] = pt(10, 10);
    set_train(0, 11, 11, 1);
    set_train(1, 15, 15, 2);
    set_train(2, 12, 12, 1);
    set_train(3, 10, 12, 3);
  endtask

  // Leaves the bench in the FETCH_A cycle of the job.
  task automatic start_job(input int n_train, input int n_test);
    cfg_n_train = n_train[TRAIN_AW:0];
    cfg_n_test  = n_test[TEST_AW:0];
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic run_and_check(input string nm, input int n_train,
                               input logic [LABEL_W-1:0] exp_label,
                               input logic [NBR_W-1:0] exp_nbr);
    int n;
    done_seen = 0;
    start_job(n_train, 1);
    n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL %s_wait: res_valid=%0b required 1 after %0d cycles", nm, res_valid, n);
    end
    checks++;
    if (res_label !== exp_label) begin
      errors++; $display("FAIL %s_label: got %0d required %0d", nm, res_label, exp_label);
    end
    checks++;
    if (res_nbr !== exp_nbr) begin
      errors++; $display("FAIL %s_nbr: got %h required %h", nm, res_nbr, exp_nbr);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_done: done=%0b busy=%0b required 1/0", nm, done, busy);
    end
    $display("%s: label=%0d nbr0_dist=%0d done=%0b", nm, res_label, res_nbr[EW-1:LABEL_W], done);
  endtask

  task automatic check_idle_zero(input string nm);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0 || knn_valid !== 1'b0 ||
        knn_start !== 1'b0 || train_addr !== '0 || test_addr !== '0 || knn_a !== '0 ||
        knn_b !== '0 || knn_label !== '0 || res_idx !== '0 || res_label !== '0 || res_nbr !== '0) begin
      errors++;
      $display("FAIL %s: busy=%0b done=%0b rv=%0b kv=%0b ks=%0b ta=%0h sa=%0h a=%0h b=%0h l=%0h ri=%0h rl=%0h rn=%h required all 0",
               nm, busy, done, res_valid, knn_valid, knn_start, train_addr, test_addr, knn_a,
               knn_b, knn_label, res_idx, res_label, res_nbr);
    end
  endtask

  // ----------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b0; run = 1'b0; stop = 1'b0; res_ready = 1'b0;
    cfg_n_train = '0; cfg_n_test = '0;
    for (int i = 0; i < (1<<TRAIN_AW); i++) train_mem[i] = '0;
    for (int i = 0; i < (1<<TEST_AW); i++) test_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset_outputs");
    $display("reset: busy=%0b done=%0b res_valid=%0b", busy, done, res_valid);
    rst = 1'b1;
    tick();
    check_idle_zero("reset_release");
  endtask

  task automatic test_basic();
    logic [NBR_W-1:0] exp_nbr;
    exp_nbr = {ent(50, 2), ent(8, 1), ent(4, 3), ent(2, 1)};
    load_basic();
    kv_seen = 0; done_seen = 0;
    start_job(4, 1);
    checks++;
    if (busy !== 1'b1 || test_addr !== 8'd0 || knn_start !== 1'b0) begin
      errors++; $display("FAIL basic_fetch: busy=%0b test_addr=%0d knn_start=%0b required 1/0/0", busy, test_addr, knn_start);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 3) begin
        checks++;
        if (knn_valid !== 1'b1 || knn_b !== pt(11, 11) || knn_label !== 8'd1 || knn_a !== pt(10, 10)) begin
          errors++; $display("FAIL basic_cand0: valid=%0b a=%h b=%h label=%0d required 1/%h/%h/1",
                             knn_valid, knn_a, knn_b, knn_label, pt(10, 10), pt(11, 11));
        end
      end
    end
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early: res_valid=%0b at f+8 required 0", res_valid);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL basic_latency: res_valid=%0b at f+9 required 1", res_valid);
    end
    checks++;
    if (res_nbr !== exp_nbr) begin
      errors++; $display("FAIL basic_nbr: got %h required %h", res_nbr, exp_nbr);
    end
    checks++;
    if (res_label !== 8'd1 || res_idx !== 8'd0) begin
      errors++; $display("FAIL basic_label: label=%0d idx=%0d required 1/0", res_label, res_idx);
    end
    checks++;
    if (kv_seen != 4) begin
      errors++; $display("FAIL basic_kvalid: knn_valid cycles=%0d required 4", kv_seen);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL basic_done: done=%0b busy=%0b rv=%0b required 1/0/0", done, busy, res_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || done_seen != 1) begin
      errors++; $display("FAIL basic_done_pulse: done=%0b count=%0d required 0/1", done, done_seen);
    end
    $display("basic: label=%0d idx=%0d nbr=%h", res_label, res_idx, res_nbr);
  endtask

  task automatic test_tie();
    test_mem[0] = pt(0, 0);
    set_train(0, 3, 0, 5);
    set_train(1, 1, 0, 5);
    set_train(2, 4, 0, 7);
    set_train(3, 2, 0, 7);
    run_and_check("tie", 4, 8'd5, {ent(16, 7), ent(9, 5), ent(4, 7), ent(1, 5)});
  endtask

  task automatic test_fewer_than_k();
    test_mem[0] = pt(0, 0);
    set_train(0, 5, 5, 4);
    set_train(1, 1, 1, 9);
    run_and_check("fewer", 2, 8'd9, {ent(NONE, 0), ent(NONE, 0), ent(50, 4), ent(2, 9)});
  endtask

  task automatic test_back_to_back();
    logic [LABEL_W-1:0] exp_lbl [3];
    logic [NBR_W-1:0]   exp_nbr1;
    int n;
    exp_lbl[0] = 8'd1; exp_lbl[1] = 8'd2; exp_lbl[2] = 8'd4;
    exp_nbr1 = {ent(162, 3), ent(82, 4), ent(82, 1), ent(2, 2)};
    test_mem[0] = pt(1, 1);
    test_mem[1] = pt(9, 1);
    test_mem[2] = pt(9, 9);
    set_train(0, 0, 0, 1);
    set_train(1, 10, 0, 2);
    set_train(2, 0, 10, 3);
    set_train(3, 10, 10, 4);
    done_seen = 0;
    start_job(4, 3);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!res_valid && n < 200) begin tick(); n++; end
      checks++;
      if (res_valid !== 1'b1 || res_idx !== k[TEST_AW-1:0] || res_label !== exp_lbl[k] ||
          res_nbr[EW-1:LABEL_W] !== 32'd2) begin
        errors++; $display("FAIL bp_result%0d: rv=%0b idx=%0d label=%0d d0=%0d required 1/%0d/%0d/2",
                           k, res_valid, res_idx, res_label, res_nbr[EW-1:LABEL_W], k, exp_lbl[k]);
      end
      $display("bp: result idx=%0d label=%0d", res_idx, res_label);
      if (k == 1) begin
        for (int s = 0; s < 10; s++) begin
          tick();
          checks++;
          if (res_valid !== 1'b1 || busy !== 1'b1 || res_idx !== 8'd1 || res_label !== 8'd2 ||
              res_nbr !== exp_nbr1 || test_addr !== 8'd1 || knn_valid !== 1'b0) begin
            errors++; $display("FAIL bp_stall%0d: rv=%0b busy=%0b idx=%0d label=%0d ta=%0d kv=%0b nbr=%h required 1/1/1/2/1/0 nbr %h",
                               s, res_valid, busy, res_idx, res_label, test_addr, knn_valid, res_nbr, exp_nbr1);
          end
        end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_done: done=%0b busy=%0b required 1/0", done, busy);
    end
    repeat (3) tick();
    checks++;
    if (done_seen != 1) begin
      errors++; $display("FAIL bp_done_count: %0d required 1", done_seen);
    end
  endtask

  task automatic test_zero_count();
    load_basic();
    done_seen = 0; kv_seen = 0; rv_seen = 0;
    start_job(0, 1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_train_done: done=%0b busy=%0b required 1/0", done, busy);
    end
    repeat (3) tick();
    start_job(4, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_test_done: done=%0b busy=%0b required 1/0", done, busy);
    end
    repeat (20) tick();
    checks++;
    if (kv_seen != 0 || rv_seen != 0 || done_seen != 2) begin
      errors++; $display("FAIL zero_quiet: knn_valid=%0d res_valid=%0d done=%0d required 0/0/2", kv_seen, rv_seen, done_seen);
    end
    $display("zero: done pulses=%0d", done_seen);
  endtask

  task automatic test_abort_reset();
    load_basic();
    done_seen = 0;
    start_job(4, 1);
    repeat (4) tick();
    checks++;
    if (knn_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre: kv=%0b busy=%0b required 1/1", knn_valid, busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle_zero("abort_stop");
    repeat (10) tick();
    checks++;
    if (done_seen != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: done=%0d busy=%0b required 0/0", done_seen, busy);
    end
    start_job(4, 1);
    repeat (6) tick();
    checks++;
    if (knn_start !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_pre: knn_start=%0b busy=%0b required 1/1", knn_start, busy);
    end
    #2 rst = 1'b0;
    #1;
    check_idle_zero("reset_async");
    #1 rst = 1'b1;
    tick();
    $display("abort: busy=%0b knn_start=%0b", busy, knn_start);
    run_and_check("after_reset", 4, 8'd1, {ent(50, 2), ent(8, 1), ent(4, 3), ent(2, 1)});
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_fewer_than_k();
    test_back_to_back();
    test_zero_count();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
